uart_tx_fifo_drain: RTL and testbench

- UART transmitter that sits directly downstream of the TX-side async FIFO, in the FIFO read-clock domain.
- Pops bytes from the FIFO's first-word-fall-through read port (data valid whenever not empty) and serialises them onto txd.
- Frame format: start bit, DATA_WIDTH bits LSB-first, optional parity bit, 1 or 2 stop bits.
- Baud rate is set by a fixed clocks-per-bit divider.

---
 rtl/uart_tx_fifo_drain_if.sv | 22 ++
 rtl/uart_tx_fifo_drain.sv | 157 +++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_drain_if.sv
// Read port of the TX-side FWFT FIFO as seen by the UART drain.
// Ports: fifo_rdata (head word, valid while !fifo_empty), fifo_empty, fifo_rinc (pop strobe).
// master = the UART that pops the FIFO, slave = the FIFO itself.
interface uart_tx_fifo_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_empty;
  logic                  fifo_rinc;

  modport master (
    input  fifo_rdata,
    input  fifo_empty,
    output fifo_rinc
  );

  modport slave (
    output fifo_rdata,
    output fifo_empty,
    input  fifo_rinc
  );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a first-word-fall-through FIFO: start, DATA_WIDTH bits LSB-first,
// optional parity, 1 or 2 stop bits, CLKS_PER_BIT clocks per bit, all outputs registered.
// Ports: clk, rst (sync, active-high), tx_en (gates new frames), fifo (FIFO read port),
// txd (serial line, idle 1), busy (high for the whole frame).
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tx_en,
  uart_tx_fifo_drain_if.master       fifo,
  output logic                       txd,
  output logic                       busy
);

  localparam int DIV_W   = $clog2(CLKS_PER_BIT);
  localparam int CNT_MAX = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  if (CLKS_PER_BIT < 2) begin : g_bad_div
    $error("CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [DIV_W-1:0]      div;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic                  parity_bit;
  logic                  rinc;
  logic                  div_last;

  assign div_last       = (div == DIV_W'(CLKS_PER_BIT - 1));
  // Data bits leave from bit 0; the register shifts right at every data-bit boundary.
  assign shift_nxt      = shift_reg >> 1;
  assign fifo.fifo_rinc = rinc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      txd        <= 1'b1;
      busy       <= 1'b0;
      rinc       <= 1'b0;
      bit_cnt    <= '0;
      div        <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
    end else begin
      // Pop strobe is a single cycle: it only survives the launch edge.
      rinc <= 1'b0;
      case (state)
        IDLE: begin
          div     <= '0;
          bit_cnt <= '0;
          if (tx_en && !fifo.fifo_empty) begin
            // Head word is captured here; the pop lands one edge later, so the
            // FIFO pointer only moves after the data is safely held.
            shift_reg  <= fifo.fifo_rdata;
            parity_bit <= (^fifo.fifo_rdata) ^ (PARITY_ODD != 0);
            state      <= START;
            txd        <= 1'b0;
            busy       <= 1'b1;
            rinc       <= 1'b1;
          end else begin
            txd  <= 1'b1;
            busy <= 1'b0;
          end
        end

        START: begin
          if (div_last) begin
            div     <= '0;
            bit_cnt <= '0;
            state   <= DATA;
            txd     <= shift_reg[0];
          end else begin
            div <= div + 1'b1;
          end
        end

        DATA: begin
          if (div_last) begin
            div <= '0;
            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                txd   <= parity_bit;
              end else begin
                state <= STOP;
                txd   <= 1'b1;
              end
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              shift_reg <= shift_nxt;
              txd       <= shift_nxt[0];
            end
          end else begin
            div <= div + 1'b1;
          end
        end

        PARITY: begin
          if (div_last) begin
            div     <= '0;
            bit_cnt <= '0;
            state   <= STOP;
            txd     <= 1'b1;
          end else begin
            div <= div + 1'b1;
          end
        end

        STOP: begin
          if (div_last) begin
            div <= '0;
            if (bit_cnt == CNT_W'(STOP_BITS - 1)) begin
              // busy drops on the same edge so IDLE always shows at least one quiet cycle.
              bit_cnt <= '0;
              state   <= IDLE;
              busy    <= 1'b0;
              txd     <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          txd     <= 1'b1;
          busy    <= 1'b0;
          div     <= '0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: four lanes with different frame formats share clk/rst/tx_en,
// each fed by its own FWFT FIFO model; per-cycle {txd,busy,rinc} traces are checked against
// a bit-slot model of the frame.
`timescale 1ns/1ps
module tb_uart_tx_fifo_drain;
  localparam int NL  = 4;
  localparam int CPB = 4;
  localparam int TRN = 4096;
  // lane 0: 8N1, lane 1: 8E1, lane 2: 8O1, lane 3: 8E2
  localparam logic [NL-1:0] PE_V  = 4'b1110;
  localparam logic [NL-1:0] PO_V  = 4'b0100;
  localparam logic [NL-1:0] SB2_V = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_en = 1'b0;
  logic [NL-1:0] txd_a, busy_a, rinc_a;
  logic [7:0] mem [NL][64];
  int wr [NL];
  int rd_a [NL];
  logic [2:0] tr [NL][TRN];
  int tn = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : lane
    uart_tx_fifo_drain_if #(.DATA_WIDTH(8)) fif ();
    int rd = 0;
    assign fif.fifo_empty = (wr[g] == rd);
    assign fif.fifo_rdata = mem[g][rd % 64];
    assign rinc_a[g]      = fif.fifo_rinc;
    assign rd_a[g]        = rd;
    always @(posedge clk) if (fif.fifo_rinc) rd <= rd + 1;

    uart_tx_fifo_drain #(
      .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(int'(PE_V[g])),
      .PARITY_ODD(int'(PO_V[g])), .STOP_BITS(SB2_V[g] ? 2 : 1)
    ) dut (
      .clk(clk), .rst(rst), .tx_en(tx_en), .fifo(fif),
      .txd(txd_a[g]), .busy(busy_a[g])
    );
  end

  always @(negedge clk) begin
    if (tn < TRN) begin
      for (int l = 0; l < NL; l++) tr[l][tn] <= {txd_a[l], busy_a[l], rinc_a[l]};
      tn <= tn + 1;
    end
  end

  // ---------------- reference model ----------------
  function automatic int frame_len(int l);
    return CPB * (1 + 8 + int'(PE_V[l]) + (SB2_V[l] ? 2 : 1));
  endfunction

  function automatic logic exp_txd(int l, logic [7:0] b, int k);
    int slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (PE_V[l] && slot == 9) return (^b) ^ PO_V[l];
    return 1'b1;
  endfunction

  // Expected {txd,busy,rinc} at offset k from the first START cycle; k == frame_len is idle.
  function automatic logic [2:0] exp_word(int l, logic [7:0] b, int k);
    if (k >= frame_len(l)) return 3'b100;
    return {exp_txd(l, b, k), 1'b1, (k == 0)};
  endfunction

  function automatic logic lanes_idle();
    for (int l = 0; l < NL; l++)
      if (rd_a[l] != wr[l] || busy_a[l] !== 1'b0 || rinc_a[l] !== 1'b0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(int l, logic [7:0] b);
    mem[l][wr[l] % 64] = b;
    wr[l] = wr[l] + 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int t0;
    push(0, 8'hA5); push(1, 8'h07); push(2, 8'h07); push(3, 8'h07);
    tx_en = 1'b1;
    rst   = 1'b1;
    tick(1);
    t0 = tn;
    tick(3);
    for (int t = t0; t < tn; t++)
      for (int l = 0; l < NL; l++) begin
        n_cmp++;
        if (tr[l][t] !== 3'b100) begin
          n_bad++;
          $display("FAIL reset lane%0d t=%0d: txd/busy/rinc got %b required 100", l, t, tr[l][t]);
        end
      end
  endtask

  task automatic test_single_and_parity();
    int t0, p, np, nb;
    logic [7:0] b;
    int busy_lit [NL] = '{40, 44, 44, 48};
    logic [NL-1:0] par_lit = 4'b1010;
    t0  = tn;
    rst = 1'b0;
    tick(60);
    for (int l = 0; l < NL; l++) begin
      b = (l == 0) ? 8'hA5 : 8'h07;
      p = -1; np = 0; nb = 0;
      for (int t = t0; t < tn; t++) begin
        if (tr[l][t][0]) begin np++; if (p < 0) p = t; end
        if (tr[l][t][1]) nb++;
      end
      n_cmp++;
      if (np !== 1) begin
        n_bad++; $display("FAIL single_pops lane%0d: got %0d required 1", l, np);
      end
      n_cmp++;
      if (nb !== busy_lit[l]) begin
        n_bad++; $display("FAIL frame_len lane%0d: busy cycles got %0d required %0d", l, nb, busy_lit[l]);
      end
      if (p >= 0) begin
        for (int k = 0; k <= frame_len(l); k++) begin
          n_cmp++;
          if (tr[l][p+k] !== exp_word(l, b, k)) begin
            n_bad++;
            $display("FAIL single_wave lane%0d k=%0d: got %b required %b", l, k, tr[l][p+k], exp_word(l, b, k));
          end
        end
        if (l > 0) begin
          n_cmp++;
          if (tr[l][p+36][2] !== par_lit[l]) begin
            n_bad++; $display("FAIL parity_bit lane%0d: got %b required %b", l, tr[l][p+36][2], par_lit[l]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0, np, idle, last;
    int pf [2];
    logic [7:0] bs [2];
    bs[0] = 8'h55; bs[1] = 8'hAA;
    pf[0] = -1; pf[1] = -1;
    t0 = tn;
    push(0, bs[0]); push(0, bs[1]);
    tick(100);
    np = 0; last = -1;
    for (int t = t0; t < tn; t++) begin
      if (tr[0][t][0]) begin
        if (np < 2) pf[np] = t;
        np++;
      end
      if (tr[0][t][1]) last = t;
    end
    n_cmp++;
    if (np !== 2) begin n_bad++; $display("FAIL b2b_pops: got %0d required 2", np); end
    if (pf[1] >= 0) begin
      n_cmp++;
      if (pf[1] - pf[0] !== 41) begin
        n_bad++; $display("FAIL b2b_spacing: got %0d required 41", pf[1] - pf[0]);
      end
      idle = 0;
      for (int t = pf[0] + 1; t < pf[1]; t++) if (tr[0][t][1] === 1'b0) idle++;
      n_cmp++;
      if (idle !== 1) begin n_bad++; $display("FAIL b2b_idle: got %0d required 1", idle); end
      n_cmp++;
      if (last - pf[0] + 1 !== 81) begin
        n_bad++; $display("FAIL b2b_total: got %0d required 81", last - pf[0] + 1);
      end
      for (int f = 0; f < 2; f++)
        for (int k = 0; k < 40; k++) begin
          n_cmp++;
          if (tr[0][pf[f]+k] !== exp_word(0, bs[f], k)) begin
            n_bad++;
            $display("FAIL b2b_wave f%0d k=%0d: got %b required %b", f, k, tr[0][pf[f]+k], exp_word(0, bs[f], k));
          end
        end
    end
  endtask

  task automatic test_enable();
    int t0, t1, w, np, nb;
    tx_en = 1'b0;
    push(0, 8'h3C); push(0, 8'hC3);
    t0 = tn;
    tick(20);
    for (int t = t0; t < tn; t++) begin
      n_cmp++;
      if (tr[0][t] !== 3'b100) begin
        n_bad++; $display("FAIL enable_block t=%0d: got %b required 100", t, tr[0][t]);
      end
    end
    tx_en = 1'b1;
    w = 0;
    while (rinc_a[0] !== 1'b1 && w < 5) begin tick(1); w++; end
    n_cmp++;
    if (rinc_a[0] !== 1'b1) begin n_bad++; $display("FAIL enable_launch: rinc got %b required 1", rinc_a[0]); end
    t1 = tn;
    tick(10);
    tx_en = 1'b0;
    tick(60);
    np = 0; nb = 0;
    for (int t = t1; t < tn; t++) begin
      if (tr[0][t][0]) np++;
      if (tr[0][t][1]) nb++;
    end
    n_cmp++;
    if (np !== 1) begin n_bad++; $display("FAIL enable_pops: got %0d required 1", np); end
    n_cmp++;
    if (nb !== 40) begin n_bad++; $display("FAIL enable_len: got %0d required 40", nb); end
    for (int k = 0; k <= 40; k++) begin
      n_cmp++;
      if (tr[0][t1+k] !== exp_word(0, 8'h3C, k)) begin
        n_bad++; $display("FAIL enable_wave k=%0d: got %b required %b", k, tr[0][t1+k], exp_word(0, 8'h3C, k));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int t0, w, np, p2;
    t0 = tn;
    tx_en = 1'b1;
    w = 0;
    while (rinc_a[0] !== 1'b1 && w < 5) begin tick(1); w++; end
    n_cmp++;
    if (rinc_a[0] !== 1'b1) begin n_bad++; $display("FAIL midrst_launch: rinc got %b required 1", rinc_a[0]); end
    tick(17);  // now inside data bit 3 (offsets 16..19)
    rst = 1'b1;
    tick(1);
    n_cmp++;
    if ({txd_a[0], busy_a[0], rinc_a} !== {2'b10, 4'b0000}) begin
      n_bad++; $display("FAIL midrst_state: txd/busy/rinc got %b%b%b required 100000", txd_a[0], busy_a[0], rinc_a);
    end
    push(0, 8'h96);
    tick(2);
    rst = 1'b0;
    tick(60);
    np = 0; p2 = -1;
    for (int t = t0; t < tn; t++)
      if (tr[0][t][0]) begin np++; p2 = t; end
    n_cmp++;
    if (np !== 2) begin n_bad++; $display("FAIL midrst_pops: got %0d required 2", np); end
    if (p2 >= 0 && p2 + 40 < tn)
      for (int k = 0; k <= 40; k++) begin
        n_cmp++;
        if (tr[0][p2+k] !== exp_word(0, 8'h96, k)) begin
          n_bad++; $display("FAIL midrst_wave k=%0d: got %b required %b", k, tr[0][p2+k], exp_word(0, 8'h96, k));
        end
      end
  endtask

  task automatic test_random();
    int t0, w, fs, nf, o;
    int base [NL];
    int npush [NL];
    logic [7:0] b;
    tx_en = 1'b1;
    for (int l = 0; l < NL; l++) begin base[l] = wr[l]; npush[l] = 0; end
    t0 = tn;
    for (int c = 0; c < 500; c++) begin
      for (int l = 0; l < NL; l++)
        if ($urandom_range(0, 39) == 0 && npush[l] < 10) begin
          push(l, 8'($urandom));
          npush[l]++;
        end
      tick(1);
    end
    w = 0;
    while (!lanes_idle() && w < 3000) begin tick(1); w++; end
    n_cmp++;
    if (w >= 3000) begin n_bad++; $display("FAIL random_drain: timed out after %0d cycles required idle", w); end
    tick(2);
    n_cmp++;
    if (tn >= TRN) begin n_bad++; $display("FAIL random_trace: length %0d required < %0d", tn, TRN); end
    for (int l = 0; l < NL; l++) begin
      fs = -1; nf = 0; b = 8'h00;
      for (int t = t0; t < tn; t++) begin
        if (fs >= 0 && t - fs >= frame_len(l)) fs = -1;
        if (fs < 0) begin
          if (tr[l][t][0] === 1'b1) begin
            if (t > t0) begin
              n_cmp++;
              if (tr[l][t-1] !== 3'b100) begin
                n_bad++; $display("FAIL random_gap lane%0d t=%0d: prior cycle %b required 100", l, t, tr[l][t-1]);
              end
            end
            fs = t;
            b  = mem[l][(base[l] + nf) % 64];
            nf++;
          end else begin
            n_cmp++;
            if (tr[l][t] !== 3'b100) begin
              n_bad++; $display("FAIL random_idle lane%0d t=%0d: got %b required 100", l, t, tr[l][t]);
            end
          end
        end
        if (fs >= 0) begin
          o = t - fs;
          n_cmp++;
          if (tr[l][t] !== exp_word(l, b, o)) begin
            n_bad++; $display("FAIL random_wave lane%0d t=%0d k=%0d: got %b required %b", l, t, o, tr[l][t], exp_word(l, b, o));
          end
        end
      end
      n_cmp++;
      if (nf !== npush[l]) begin
        n_bad++; $display("FAIL random_frames lane%0d: got %0d required %0d", l, nf, npush[l]);
      end
    end
  endtask

  initial begin
    for (int l = 0; l < NL; l++) wr[l] = 0;
    test_reset();
    test_single_and_parity();
    test_back_to_back();
    test_enable();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
